// File: rtl/maxpool_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// maxpool_fifo_ctrl
//
// Sequences a row-pair max-pooling pass over a tile coming out of a systolic
// array. Even rows are written into a FIFO array that is SYSTOLIC_SIZE deep.
// Odd rows read that FIFO back beat-for-beat, so the stored row and the live
// row can be compared. cmp_valid marks the cycle where the FIFO output and the
// one-cycle-delayed incoming row line up for the downstream max comparator.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   single-cycle tile start request, sampled only in IDLE
//   in_valid   in   one row element (all lanes) present this cycle
//   in_ready   out  controller is accepting row beats (WRITE_ROW/READ_ROW)
//   wr_en      out  FIFO array write enable (combinational from in_valid)
//   rd_en      out  FIFO array read enable (combinational from in_valid)
//   wr_clr     out  FIFO array write-pointer clear
//   rd_clr     out  FIFO array read-pointer clear
//   cmp_valid  out  FIFO output and delayed row aligned; comparator takes max
//   busy       out  a tile is in progress
//   done       out  single-cycle pulse at the end of the tile
// ---------------------------------------------------------------------------
module maxpool_fifo_ctrl #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int NUM_ROWS      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic in_valid,
    output logic in_ready,
    output logic wr_en,
    output logic rd_en,
    output logic wr_clr,
    output logic rd_clr,
    output logic cmp_valid,
    output logic busy,
    output logic done
);

    localparam int COL_W  = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
    localparam int NPAIR  = NUM_ROWS / 2;
    localparam int PAIR_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SYSTOLIC_SIZE - 1);
    localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(NPAIR - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        WRITE_ROW = 3'd2,
        READ_ROW  = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [PAIR_W-1:0]   pair_q, pair_d;
    logic                cmp_valid_q, cmp_valid_d;
    logic                done_q, done_d;
    logic                row_active;
    logic                beat;

    // Beats are only accepted in the two row states; in_valid elsewhere has
    // no effect on counters or enables.
    assign row_active = (state_q == WRITE_ROW) || (state_q == READ_ROW);
    assign beat       = in_valid && row_active;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        pair_d  = pair_q;

        case (state_q)
            IDLE: begin
                col_d  = '0;
                pair_d = '0;
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = WRITE_ROW;
            end
            WRITE_ROW: begin
                if (beat) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = READ_ROW;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            READ_ROW: begin
                if (beat) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        // FIFO pointers wrap on their own after a full row,
                        // so the next pair goes straight back to WRITE_ROW.
                        if (pair_q == PAIR_LAST) begin
                            pair_d  = '0;
                            state_d = DONE;
                        end else begin
                            pair_d  = pair_q + 1'b1;
                            state_d = WRITE_ROW;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // FIFO read data appears one cycle after rd_en.
        cmp_valid_d = beat && (state_q == READ_ROW);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            pair_q      <= '0;
            cmp_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            pair_q      <= pair_d;
            cmp_valid_q <= cmp_valid_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = row_active;
    assign wr_en     = in_valid && (state_q == WRITE_ROW);
    assign rd_en     = in_valid && (state_q == READ_ROW);
    assign wr_clr    = (state_q == CLEAR);
    assign rd_clr    = (state_q == CLEAR);
    assign cmp_valid = cmp_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_maxpool_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_maxpool_fifo_ctrl
//
// Directed bench for maxpool_fifo_ctrl with SYSTOLIC_SIZE=4, NUM_ROWS=4.
// Cycle 0 of a tile is the cycle on which start is presented; with in_valid
// held high CLEAR is cycle 1, rows occupy cycles 2-5, 6-9, 10-13, 14-17 and
// done appears on cycle 18.
// ---------------------------------------------------------------------------
module tb_maxpool_fifo_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic in_valid;
    logic in_ready, wr_en, rd_en, wr_clr, rd_clr, cmp_valid, busy, done;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Per-tile tallies filled in by run_tile.
    int n_wr, n_rd, n_clr, n_cmp, n_misal, n_bad_en, n_done;
    int done_cyc, first_wr, first_rd, first_clr, n_post_bad, fin;

    maxpool_fifo_ctrl #(
        .SYSTOLIC_SIZE(4),
        .NUM_ROWS     (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .wr_clr   (wr_clr),
        .rd_clr   (rd_clr),
        .cmp_valid(cmp_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int want);
        n_compared++;
        if (obs != want) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
        end
    endtask

    function automatic int outs_vec();
        return {24'd0, in_ready, wr_en, rd_en, wr_clr, rd_clr, cmp_valid, busy, done};
    endfunction

    // vmode 0: in_valid held high; vmode 1: in_valid high on odd cycles.
    // ra/rb: extra cycles on which start is re-pulsed (-1 for none).
    // rst_cyc: cycle on which rst_n is asserted (-1 for none).
    // post: idle cycles checked after done.
    task automatic run_tile(input int vmode, input int ra, input int rb,
                            input int rst_cyc, input int post);
        logic prev_rd;
        n_wr = 0; n_rd = 0; n_clr = 0; n_cmp = 0; n_misal = 0; n_bad_en = 0;
        n_done = 0; done_cyc = -1; first_wr = -1; first_rd = -1; first_clr = -1;
        n_post_bad = 0; fin = 0;
        prev_rd = 1'b0;
        for (int c = 0; c < 200 && fin == 0; c++) begin
            @(negedge clk);
            start    = (c == 0) || (c == ra) || (c == rb);
            in_valid = (vmode == 0) ? 1'b1 : c[0];
            #1;
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("rst_async_outs", outs_vec(), 0);
                chk("rst_no_done_before", n_done, 0);
                start = 1'b0;
                return;
            end
            if (wr_en) begin n_wr++; if (first_wr < 0) first_wr = c; end
            if (rd_en) begin n_rd++; if (first_rd < 0) first_rd = c; end
            if ((wr_en || rd_en) && !in_valid) n_bad_en++;
            if (wr_en && rd_en) n_bad_en++;
            if (wr_clr != rd_clr) n_bad_en++;
            if (wr_clr) begin n_clr++; if (first_clr < 0) first_clr = c; end
            if (cmp_valid) n_cmp++;
            if (cmp_valid != prev_rd) n_misal++;
            prev_rd = rd_en;
            if (done) begin n_done++; done_cyc = c; fin = 1; end
        end
        chk("tile_finished", fin, 1);
        for (int p = 0; p < post; p++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b1;
            #1;
            if (busy || cmp_valid || done || in_ready || wr_en || rd_en || wr_clr)
                n_post_bad++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        in_valid = 1'b1;

        // Reset state, with start and in_valid active to show they are masked.
        @(negedge clk);
        chk("reset_outs", outs_vec(), 0);
        @(negedge clk);
        chk("reset_outs_held", outs_vec(), 0);
        start = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("release_idle_busy", busy, 0);

        // Full tile, in_valid held high.
        run_tile(0, -1, -1, -1, 2);
        chk("t1_first_clr",  first_clr, 1);
        chk("t1_clr_cycles", n_clr, 1);
        chk("t1_first_wr",   first_wr, 2);
        chk("t1_first_rd",   first_rd, 6);
        chk("t1_wr_count",   n_wr, 8);
        chk("t1_rd_count",   n_rd, 8);
        chk("t1_cmp_count",  n_cmp, 8);
        chk("t1_cmp_align",  n_misal, 0);
        chk("t1_done_cycle", done_cyc, 18);
        chk("t1_bad_enable", n_bad_en, 0);
        chk("t1_post_idle",  n_post_bad, 0);

        // in_valid toggling: beats on odd cycles 3..33, done on 34.
        run_tile(1, -1, -1, -1, 1);
        chk("t2_wr_count",   n_wr, 8);
        chk("t2_rd_count",   n_rd, 8);
        chk("t2_cmp_count",  n_cmp, 8);
        chk("t2_cmp_align",  n_misal, 0);
        chk("t2_bad_enable", n_bad_en, 0);
        chk("t2_done_cycle", done_cyc, 34);
        chk("t2_done_count", n_done, 1);

        // start re-pulsed in WRITE_ROW (cycle 3) and in DONE (cycle 18).
        run_tile(0, 3, 18, -1, 3);
        chk("t3_clr_cycles", n_clr, 1);
        chk("t3_done_count", n_done, 1);
        chk("t3_done_cycle", done_cyc, 18);
        chk("t3_post_idle",  n_post_bad, 0);

        // in_valid high while idle: nothing moves.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b1;
            #1;
            chk("idle_valid_outs", outs_vec(), 0);
        end

        // Reset on the 2nd READ_ROW beat (cycle 7), then a fresh tile.
        run_tile(0, -1, -1, 7, 0);
        @(negedge clk);
        chk("rst_held_outs", outs_vec(), 0);
        rst_n = 1'b1;
        run_tile(0, -1, -1, -1, 1);
        chk("t5_clr_cycles", n_clr, 1);
        chk("t5_first_clr",  first_clr, 1);
        chk("t5_wr_count",   n_wr, 8);
        chk("t5_rd_count",   n_rd, 8);
        chk("t5_done_cycle", done_cyc, 18);

        // Back-to-back: second start on the cycle right after done.
        run_tile(0, -1, -1, -1, 0);
        chk("t6a_done_cycle", done_cyc, 18);
        run_tile(0, -1, -1, -1, 2);
        chk("t6b_first_clr",  first_clr, 1);
        chk("t6b_clr_cycles", n_clr, 1);
        chk("t6b_wr_count",   n_wr, 8);
        chk("t6b_rd_count",   n_rd, 8);
        chk("t6b_cmp_count",  n_cmp, 8);
        chk("t6b_cmp_align",  n_misal, 0);
        chk("t6b_done_cycle", done_cyc, 18);
        chk("t6b_post_idle",  n_post_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/maxpool_fifo_ctrl.md
MAXPOOL_FIFO_CTRL -- requirements
Module: maxpool_fifo_ctrl

Interface
REQ-001 Parameter SYSTOLIC_SIZE, default 16, is the row length in beats and equals the depth of the maxpool FIFO array being driven.
REQ-002 Parameter NUM_ROWS, default 16, is the number of rows per tile; it SHALL be even and at least 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle tile start request; sampled only in IDLE.
REQ-007 in_valid  input  1  one row element (all lanes) present on the systolic output this cycle.
REQ-008 in_ready  output  1  controller is accepting row beats.
REQ-009 wr_en  output  1  FIFO array write enable.
REQ-010 rd_en  output  1  FIFO array read enable.
REQ-011 wr_clr  output  1  FIFO array write-pointer clear.
REQ-012 rd_clr  output  1  FIFO array read-pointer clear.
REQ-013 cmp_valid  output  1  FIFO output and the delayed incoming row are aligned; the downstream comparator takes max.
REQ-014 busy  output  1  a tile is in progress.
REQ-015 done  output  1  single-cycle pulse at the end of the tile.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, WRITE_ROW, READ_ROW and DONE.
REQ-017 IDLE with start=1 -> CLEAR; otherwise the FSM SHALL stay in IDLE.
REQ-018 CLEAR SHALL last exactly 1 cycle, with wr_clr=rd_clr=1, then -> WRITE_ROW; clr outputs SHALL be 0 in every other state.
REQ-019 in_ready SHALL be 1 exactly in WRITE_ROW and READ_ROW.
REQ-020 wr_en SHALL equal in_valid in WRITE_ROW and be 0 elsewhere (combinational).
REQ-021 rd_en SHALL equal in_valid in READ_ROW and be 0 elsewhere (combinational).
REQ-022 in_valid outside WRITE_ROW/READ_ROW SHALL be ignored: no counter change, no enables.
REQ-023 The column counter (width clog2(SYSTOLIC_SIZE)) SHALL increment on each accepted beat.
REQ-024 When an accepted beat hits column SYSTOLIC_SIZE-1, the column counter SHALL wrap to 0 and the FSM SHALL change row state.
REQ-025 WRITE_ROW last beat -> READ_ROW.
REQ-026 READ_ROW last beat -> DONE if the pair counter = NUM_ROWS/2-1, else -> WRITE_ROW with the pair counter +1.
REQ-027 FIFO pointers SHALL wrap naturally at SYSTOLIC_SIZE, so no clear SHALL be issued between row pairs.
REQ-028 cmp_valid SHALL be rd_en delayed by exactly 1 cycle (registered), matching the 1-cycle FIFO read latency.
REQ-029 cmp_valid SHALL still assert on the cycle after the final READ_ROW beat, even though the FSM is then in DONE.
REQ-030 DONE SHALL last 1 cycle with done=1, then -> IDLE; the pair counter and column counter SHALL be 0 on IDLE entry.
REQ-031 busy SHALL be 1 in CLEAR, WRITE_ROW, READ_ROW and DONE, and 0 in IDLE.
REQ-032 start asserted in any state other than IDLE SHALL be ignored; it SHALL not be queued.
REQ-033 Gaps in in_valid SHALL stall the counters with no state change; any gap length SHALL be legal.
REQ-034 Total accepted beats per tile SHALL be SYSTOLIC_SIZE*NUM_ROWS; writes per tile SHALL equal reads per tile.

Reset
REQ-035 rst_n=0 SHALL immediately, without a clock, force: state IDLE, counters 0, cmp_valid=0, done=0.
REQ-036 While rst_n=0, in_ready, wr_en, rd_en, wr_clr, rd_clr and busy SHALL all be 0.
REQ-037 Reset mid-tile SHALL abandon the tile with no done pulse; the next start SHALL re-clear the FIFOs via CLEAR.
REQ-038 Release of rst_n SHALL be treated synchronously; the first start SHALL be honoured no earlier than the first clock edge after release.

Verification (SYSTOLIC_SIZE=4, NUM_ROWS=4)
REQ-039 start pulse, then in_valid held 1 -> 1 CLEAR cycle; then 4 wr_en, 4 rd_en, 4 wr_en, 4 rd_en; done on cycle 18 after start; cmp_valid high 8 cycles total, each 1 cycle after its rd_en.
REQ-040 in_valid toggling 1,0,1,0 during the tile -> identical enable counts (16 total); done only after the 16th accepted beat; no enables on in_valid=0 cycles.
REQ-041 start re-pulsed during WRITE_ROW and in DONE -> no extra CLEAR, one done pulse only, IDLE afterwards.
REQ-042 rst_n asserted on the 2nd READ_ROW beat -> all outputs 0 asynchronously; a new start gives a CLEAR cycle and a full 16-beat tile.
REQ-043 in_valid=1 while in IDLE and CLEAR -> wr_en=rd_en=0 and counters unchanged.
REQ-044 Back-to-back tiles (start on the cycle after done) -> the second tile behaves identically to the first.
